// File: rtl/i2s_rx_fifo.sv
`timescale 1ns/1ps
// I2S master receiver: generates BCLK/WS and captures one slot per frame.
// Each sample is sign-extended to 32 bits and queued in a valid/ready FIFO.
module i2s_rx_fifo #(
    parameter int CLK_DIV    = 4,
    parameter int SAMPLE_W   = 24,
    parameter int CHANNEL    = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               HCLK,
    input  logic                               HRESETn,
    input  logic                               en,
    input  logic                               I2S_in,
    output logic                               i2s_clk,
    output logic                               ws,
    output logic [31:0]                        sample_data,
    output logic                               sample_valid,
    input  logic                               sample_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               overrun,
    input  logic                               clr_overrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW    = $clog2(FIFO_DEPTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]       BIT_FIRST = 6'(32 * CHANNEL + 1);
    localparam logic [5:0]       BIT_LAST  = 6'(32 * CHANNEL + SAMPLE_W);
    localparam logic [LW-1:0]    LVL_FULL  = LW'(FIFO_DEPTH);
    localparam logic [AW-1:0]    PTR_LAST  = AW'(FIFO_DEPTH - 1);

    logic [DIV_W-1:0]    r_div;
    logic                r_bclk;
    logic [5:0]          r_fcnt;
    logic [SAMPLE_W-1:0] r_shift;
    logic [31:0]         r_mem [0:FIFO_DEPTH-1];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [LW-1:0]       r_level;
    logic                r_overrun;

    logic                w_term;
    logic                w_rise;
    logic                w_fall;
    logic                w_cap;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_push_ok;
    logic                w_drop;
    logic [SAMPLE_W-1:0] w_shift_nxt;
    logic [31:0]         w_word;

    assign w_term = (r_div == DIV_LAST);
    assign w_rise = en & w_term & ~r_bclk;
    assign w_fall = en & w_term &  r_bclk;

    // The last captured bit goes straight into the pushed word, same edge.
    assign w_shift_nxt = (r_shift << 1) | SAMPLE_W'(I2S_in);
    assign w_cap       = w_rise & (r_fcnt >= BIT_FIRST) & (r_fcnt <= BIT_LAST);
    assign w_push      = w_rise & (r_fcnt == BIT_LAST);
    assign w_word      = {{(32 - SAMPLE_W){w_shift_nxt[SAMPLE_W-1]}}, w_shift_nxt};

    assign sample_valid = (r_level != LW'(0));
    assign w_pop        = sample_valid & sample_ready;
    assign w_full       = (r_level == LVL_FULL);
    assign w_push_ok    = w_push & (~w_full | w_pop);
    assign w_drop       = w_push & w_full & ~w_pop;

    assign i2s_clk     = r_bclk;
    assign ws          = r_fcnt[5];
    assign sample_data = sample_valid ? r_mem[r_rptr] : 32'd0;
    assign fifo_level  = r_level;
    assign overrun     = r_overrun;

    // BCLK divider; disabling parks BCLK low with the divider cleared.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (!en) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (w_term) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + DIV_W'(1);
            r_bclk <= r_bclk;
        end
    end

    // Frame bit counter and capture shift register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_fcnt  <= 6'd0;
            r_shift <= '0;
        end else if (!en) begin
            r_fcnt  <= 6'd0;
            r_shift <= '0;
        end else begin
            if (w_fall) begin
                r_fcnt <= r_fcnt + 6'd1;
            end else begin
                r_fcnt <= r_fcnt;
            end
            if (w_cap) begin
                r_shift <= w_shift_nxt;
            end else begin
                r_shift <= r_shift;
            end
        end
    end

    // Sample storage; contents are only meaningful below the level count.
    always_ff @(posedge HCLK) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    // FIFO pointers, occupancy and sticky overrun.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= (r_wptr == PTR_LAST) ? AW'(0) : r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_LAST) ? AW'(0) : r_rptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_fifo.sv
`timescale 1ns/1ps
// Directed bench for i2s_rx_fifo: a microphone model slaved to BCLK feeds
// per-frame left words; expected samples and timings are hand-derived.
module tb_i2s_rx_fifo;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        en;
    logic        I2S_in;
    logic        sample_ready;
    logic        clr_overrun;
    logic        i2s_clk;
    logic        ws;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic [3:0]  fifo_level;
    logic        overrun;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [23:0] left_tab [0:15];
    logic [23:0] mic_left = 24'd0;
    logic [23:0] mic_right = 24'h123456;
    int          mic_fc = 0;
    int          frame_idx = 0;

    i2s_rx_fifo #(
        .CLK_DIV(4), .SAMPLE_W(24), .CHANNEL(0), .FIFO_DEPTH(8)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .en(en), .I2S_in(I2S_in),
        .i2s_clk(i2s_clk), .ws(ws), .sample_data(sample_data),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .fifo_level(fifo_level), .overrun(overrun), .clr_overrun(clr_overrun)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic mic_bit(input int fc);
        if (fc >= 1 && fc <= 24) return mic_left[24 - fc];
        else if (fc >= 33 && fc <= 56) return mic_right[56 - fc];
        else return fc[0];
    endfunction

    // Microphone: shifts out the next bit on every BCLK falling edge.
    initial begin
        forever begin
            @(negedge i2s_clk);
            mic_fc = (mic_fc + 1) % 64;
            if (mic_fc == 0) begin
                frame_idx++;
                mic_left = left_tab[frame_idx % 16];
            end
            I2S_in = mic_bit(mic_fc);
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        HRESETn = 1'b0; sample_ready = 1'b0; clr_overrun = 1'b0; I2S_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            en = i[0];
            tick();
        end
        en = 1'b0;
        HRESETn = 1'b1;
        tick();
    endtask

    task automatic start_rx(input int idx);
        mic_fc = 0;
        frame_idx = idx;
        mic_left = left_tab[idx];
        I2S_in = 1'b0;
        en = 1'b1;
        cyc = 0;
    endtask

    task automatic pop_one(input string tag, input logic [31:0] exp);
        chk_eq(tag, sample_data, exp);
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
    endtask

    task automatic fill_ascending();
        for (int k = 0; k < 16; k++) left_tab[k] = 24'(k + 1);
    endtask

    initial begin
        int rise_c, fall_c, ws_up, ws_dn, ws_bad;
        logic prev_bclk, prev_ws;

        // Reset with en toggling: every output must stay at zero.
        for (int k = 0; k < 16; k++) left_tab[k] = 24'd0;
        apply_reset();
        HRESETn = 1'b0;
        for (int i = 0; i < 4; i++) begin en = i[0]; tick(); end
        chk_eq("rst_bclk", {31'd0, i2s_clk}, 32'd0);
        chk_eq("rst_ws", {31'd0, ws}, 32'd0);
        chk_eq("rst_valid", {31'd0, sample_valid}, 32'd0);
        chk_eq("rst_data", sample_data, 32'd0);
        chk_eq("rst_level", {28'd0, fifo_level}, 32'd0);
        chk_eq("rst_ovr", {31'd0, overrun}, 32'd0);
        en = 1'b0; HRESETn = 1'b1; tick();

        // Clocking and left-slot data path.
        left_tab[0] = 24'hA5C3F1;
        left_tab[1] = 24'h012345;
        left_tab[2] = 24'h0F0F0F;
        start_rx(0);
        rise_c = -1; fall_c = -1; ws_up = -1; ws_dn = -1; ws_bad = 0;
        prev_bclk = 1'b0; prev_ws = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (rise_c < 0 && i2s_clk) rise_c = cyc;
            else if (rise_c >= 0 && fall_c < 0 && !i2s_clk) fall_c = cyc;
            if (ws !== prev_ws && !(prev_bclk && !i2s_clk)) ws_bad++;
            if (ws_up < 0 && ws) ws_up = cyc;
            if (ws_up >= 0 && ws_dn < 0 && !ws) ws_dn = cyc;
            if (cyc == 195) chk_eq("lvl_pre_push", {28'd0, fifo_level}, 32'd0);
            if (cyc == 196) chk_eq("lvl_post_push", {28'd0, fifo_level}, 32'd1);
            if (cyc == 511) chk_eq("one_per_frame", {28'd0, fifo_level}, 32'd1);
            prev_bclk = i2s_clk;
            prev_ws = ws;
        end
        chk_eq("first_rise", rise_c, 32'd4);
        chk_eq("first_fall", fall_c, 32'd8);
        chk_eq("ws_rise", ws_up, 32'd256);
        chk_eq("ws_fall", ws_dn, 32'd512);
        chk_eq("ws_on_bclk_fall", ws_bad, 32'd0);
        chk_eq("lvl_two_frames", {28'd0, fifo_level}, 32'd2);
        pop_one("neg_sample", 32'hFFA5C3F1);
        pop_one("pos_sample", 32'h00012345);
        chk_eq("drained_valid", {31'd0, sample_valid}, 32'd0);
        chk_eq("drained_data", sample_data, 32'd0);

        // Overrun: nine frames with no consumer.
        apply_reset();
        fill_ascending();
        start_rx(0);
        while (cyc < 4300) begin
            tick();
            if (cyc == 4291) begin
                chk_eq("full_level", {28'd0, fifo_level}, 32'd8);
                chk_eq("ovr_pre_drop", {31'd0, overrun}, 32'd0);
            end
            if (cyc == 4292) begin
                chk_eq("drop_level", {28'd0, fifo_level}, 32'd8);
                chk_eq("ovr_set", {31'd0, overrun}, 32'd1);
            end
        end
        en = 1'b0;
        tick(); tick();
        chk_eq("dis_bclk", {31'd0, i2s_clk}, 32'd0);
        chk_eq("dis_ws", {31'd0, ws}, 32'd0);
        chk_eq("ovr_sticky", {31'd0, overrun}, 32'd1);
        for (int k = 1; k <= 8; k++) pop_one("ovr_drain", 32'(k));
        chk_eq("ovr_empty", {31'd0, sample_valid}, 32'd0);
        clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
        chk_eq("ovr_clr", {31'd0, overrun}, 32'd0);

        // Full FIFO with push and pop on the same edge.
        apply_reset();
        fill_ascending();
        start_rx(0);
        while (cyc < 4292) begin
            tick();
            if (cyc == 4291) begin
                chk_eq("simul_full", {28'd0, fifo_level}, 32'd8);
                sample_ready = 1'b1;
            end
        end
        sample_ready = 1'b0;
        chk_eq("simul_level", {28'd0, fifo_level}, 32'd8);
        chk_eq("simul_ovr", {31'd0, overrun}, 32'd0);
        en = 1'b0;
        tick();
        for (int k = 2; k <= 9; k++) pop_one("simul_drain", 32'(k));
        chk_eq("simul_empty", {31'd0, sample_valid}, 32'd0);

        // Enable abort at fcnt=10 of the second frame.
        apply_reset();
        left_tab[0] = 24'h7FFFFF;
        left_tab[1] = 24'h800000;
        left_tab[2] = 24'h800001;
        left_tab[3] = 24'h000000;
        start_rx(0);
        while (cyc < 595) tick();
        en = 1'b0;
        tick();
        chk_eq("abort_bclk", {31'd0, i2s_clk}, 32'd0);
        chk_eq("abort_level", {28'd0, fifo_level}, 32'd1);
        pop_one("abort_keep", 32'h007FFFFF);
        for (int i = 0; i < 98; i++) tick();
        chk_eq("abort_empty", {28'd0, fifo_level}, 32'd0);
        start_rx(2);
        while (cyc < 196) begin
            tick();
            if (cyc == 195) chk_eq("reen_pre_push", {28'd0, fifo_level}, 32'd0);
        end
        chk_eq("reen_level", {28'd0, fifo_level}, 32'd1);
        pop_one("reen_sample", 32'hFF800001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/i2s_rx_fifo.md
Name: i2s_rx_fifo

Overview:
- I2S master receiver; sits directly upstream of the SoC sample path (DMA / bus slave).
- Generates i2s_clk (BCLK) and ws for the external microphone and samples I2S_in.
- Extracts one channel per frame, sign-extends the sample to 32 bits and buffers it in a FIFO.
- Presents the FIFO head on a valid/ready interface.

Parameters:
- CLK_DIV, 4, HCLK cycles per BCLK half-period (>=2); BCLK period = 2*CLK_DIV HCLK.
- SAMPLE_W, 24, valid sample bits per slot (1..31).
- CHANNEL, 0, captured slot: 0 = left (ws low), 1 = right (ws high).
- FIFO_DEPTH, 8, sample entries (power of two).

Ports:
- HCLK  in  1  system clock.
- HRESETn  in  1  asynchronous active-low reset.
- en  in  1  receiver enable.
- I2S_in  in  1  serial data from the microphone.
- i2s_clk  out  1  BCLK.
- ws  out  1  word select.
- sample_data  out  32  FIFO head, sign-extended.
- sample_valid  out  1  FIFO not empty.
- sample_ready  in  1  consumer accepts the head this cycle.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  entries held.
- overrun  out  1  sticky: a sample was dropped.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Clock and reset: one clock, HCLK; reset asynchronous, active-low, HRESETn.
- Reset values: i2s_clk=0, ws=0, sample_valid=0, sample_data=0, fifo_level=0, overrun=0; divider, frame counter, shift register and FIFO pointers cleared. Reset mid-frame discards everything.
- BCLK generation:
  - Divider counts 0..CLK_DIV-1 while en=1 and toggles i2s_clk at terminal count.
  - en=0: divider, frame counter and shift register held at 0; i2s_clk=0, ws=0.
  - A partial sample is discarded; FIFO contents, pop path and overrun remain functional.
  - Re-enabling starts a fresh frame at fcnt=0.
- Frame counter fcnt (0..63):
  - Increments on each BCLK falling toggle (1->0) and wraps 63->0.
  - ws = fcnt[5]: ws changes only on BCLK falling edges, 32 BCLK per slot.
- Sampling:
  - I2S_in is sampled in the HCLK cycle in which i2s_clk toggles 0->1.
  - Slot base S = 32*CHANNEL. Bits are captured MSB-first at fcnt = S+1 .. S+SAMPLE_W (standard one-BCLK I2S delay).
  - All other bit positions are ignored.
- Push:
  - On capture of the bit at fcnt = S+SAMPLE_W, the assembled word {sign-extension, sample} is written on that same HCLK edge.
  - sample_valid/fifo_level reflect the push from the next cycle.
- Pop: occurs when sample_valid && sample_ready. sample_data is stable while valid && !ready, and reads 0 when the FIFO is empty.
- Full: a push while full with no pop is dropped and overrun is set. Push and pop in the same cycle while full: both take effect, level unchanged, no overrun.
- Empty: push and pop in the same cycle cannot occur (valid=0), so the push is simply accepted.
- overrun: cleared by clr_overrun. If clr_overrun and a drop occur in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH; fifo_level is exact in 0..FIFO_DEPTH.

Test Plan:
- Reset: HRESETn=0 with en=1 toggling -> all outputs 0. Release -> first i2s_clk rise 4 HCLK after the first enabled cycle (CLK_DIV=4).
- Clocking: en=1, CLK_DIV=4 -> BCLK period 8 HCLK at 50% duty; ws toggles every 256 HCLK, only on BCLK falling edges; frame = 512 HCLK.
- Data path, CHANNEL=0:
  - Left slot 24'hA5C3F1, right slot 24'h123456 -> exactly one sample, 32'hFFA5C3F1.
  - Next frame left 24'h012345 -> 32'h00012345.
- Overrun: sample_ready=0 for 9 frames -> fifo_level=8, overrun=1. Draining yields samples 1..8 in order (9th absent). clr_overrun pulse -> overrun=0.
- Simultaneous full push/pop: FIFO full, sample_ready=1 exactly on the push cycle -> level stays 8, overrun stays 0, oldest entry popped.
- Enable abort: drop en at fcnt=10, re-enable 100 HCLK later -> no sample from the aborted frame. Next complete frame produces a correct sample. FIFO entries present before the abort remain poppable during en=0.
